// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_pkg
// Purpose  : Shared CPU definitions for the instruction-fetch sequencer:
//            bus-source bit indices of the 24-bit drive vector, state
//            encoding and the default memory wait limit.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

  // Bus-source bit indices (drive vector feeding the 24-to-5 encoder)
  localparam int R0OUT_IDX      = 0;
  localparam int R1OUT_IDX      = 1;
  localparam int R2OUT_IDX      = 2;
  localparam int R3OUT_IDX      = 3;
  localparam int R4OUT_IDX      = 4;
  localparam int R5OUT_IDX      = 5;
  localparam int R6OUT_IDX      = 6;
  localparam int R7OUT_IDX      = 7;
  localparam int R8OUT_IDX      = 8;
  localparam int R9OUT_IDX      = 9;
  localparam int R10OUT_IDX     = 10;
  localparam int R11OUT_IDX     = 11;
  localparam int R12OUT_IDX     = 12;
  localparam int R13OUT_IDX     = 13;
  localparam int R14OUT_IDX     = 14;
  localparam int R15OUT_IDX     = 15;
  localparam int HIOUT_IDX      = 16;
  localparam int LOOUT_IDX      = 17;
  localparam int ZHIGHOUT_IDX   = 18;
  localparam int ZLOWOUT_IDX    = 19;
  localparam int PCOUT_IDX      = 20;
  localparam int MDROUT_IDX     = 21;
  localparam int INPORTOUT_IDX  = 22;
  localparam int COUT_IDX       = 23;

  localparam int DRIVE_W        = 24;
  localparam int COUNT_W        = 16;

  // Default maximum number of T1 cycles spent waiting for mem_ready
  localparam int TIMEOUT_DEFAULT = 15;

  // State encoding
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_T0    = 3'd1,
    ST_T1    = 3'd2,
    ST_T2    = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  // One-hot drive vector selecting a single bus source
  function automatic logic [DRIVE_W-1:0] drive_onehot(input int idx);
    return {{(DRIVE_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage : fetch_sequencer_pkg
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction-fetch control sequencer (IDLE -> T0 -> T1 -> T2)
//            with a bounded memory wait in T1 and a sticky FAULT state.
// Ports    : clock       - rising-edge clock
//            clear       - synchronous active-high reset
//            start       - request one fetch (sampled in IDLE only)
//            mem_ready   - memory read data valid on Mdatain
//            drive       - one-hot bus-source select (0 in IDLE/FAULT)
//            PCin, MARin, IncPC, Zin, Read, MDRin, IRin - datapath strobes
//            busy        - high in every state except IDLE
//            fetch_done  - one-cycle pulse while IR is loaded (T2)
//            fault       - memory timeout flag, held until clear
//            fetch_count - completed fetches, modulo 2^16
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
  output logic [DRIVE_W-1:0]  drive,
  output logic                PCin,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zin,
  output logic                Read,
  output logic                MDRin,
  output logic                IRin,
  output logic                busy,
  output logic                fetch_done,
  output logic                fault,
  output logic [COUNT_W-1:0]  fetch_count
);

  // Wait counter must hold TIMEOUT itself; never narrower than 4 bits
  localparam int WAIT_BITS = $clog2(TIMEOUT + 1);
  localparam int WAIT_W    = (WAIT_BITS < 4) ? 4 : WAIT_BITS;
  localparam logic [WAIT_W-1:0] C_WAIT_LIMIT = WAIT_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q,  wait_d;
  logic [COUNT_W-1:0]  count_q, count_d;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        if (start) state_d = ST_T0;
      end
      ST_T0: begin
        // Guarantees the counter reads 0 on the first T1 cycle
        wait_d  = '0;
        state_d = ST_T1;
      end
      ST_T1: begin
        // Data arriving on the limit cycle still completes the fetch
        if (mem_ready) begin
          state_d = ST_T2;
        end else if (wait_q == C_WAIT_LIMIT) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_T2: begin
        count_d = count_q + 1'b1;
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode: everything comes from the state register. MDRin is the
  // single exception: it qualifies the T1 state with mem_ready so the MDR
  // captures Mdatain in the very cycle the memory presents it.
  // --------------------------------------------------------------------------
  always_comb begin
    drive      = '0;
    PCin       = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    Zin        = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    busy       = 1'b1;
    fetch_done = 1'b0;
    fault      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_T0: begin
        drive = drive_onehot(PCOUT_IDX);
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        // PC reload repeats every wait cycle; harmless since Zlow is stable
        drive = drive_onehot(ZLOWOUT_IDX);
        PCin  = 1'b1;
        Read  = 1'b1;
        MDRin = mem_ready;
      end
      ST_T2: begin
        drive      = drive_onehot(MDROUT_IDX);
        IRin       = 1'b1;
        fetch_done = 1'b1;
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign fetch_count = count_q;

endmodule : fetch_sequencer
`default_nettype wire
